// File: rtl/avr_io_alarm_if.sv
// avr_io_alarm_if: AVR I/O bus strobes, address/data and the interrupt line of the alarm block.
interface avr_io_alarm_if;
    logic       io_re;
    logic       io_we;
    logic [2:0] io_a;
    logic [7:0] io_di;
    logic [7:0] io_do;
    logic       irq;
    modport slave (input io_re, io_we, io_a, io_di, output io_do, irq);
    modport master (output io_re, io_we, io_a, io_di, input io_do, irq);
endinterface

// File: rtl/avr_io_alarm.sv
// avr_io_alarm: NCH alarm channels sharing one 16-bit timebase and one comparator scanned a channel per clock.
// Define AVR_ALARM_PERIODIC_EN to add per-channel auto-reload periods (PER), loaded through a SEL escape.
module avr_io_alarm #(
    parameter int NCH = 4
) (
    input logic           clk,
    input logic           rst,
    avr_io_alarm_if.slave bus
);
    localparam logic [2:0] LAST = 3'(NCH - 1);
    localparam logic [7:0] CH_MASK = 8'((1 << NCH) - 1);

    logic [15:0] cnt_q, cnt_d;
    logic [7:0]  tmp_q, tmp_d, ctrl_q, ctrl_d, arm_q, arm_d, pend_q, pend_d, rdata;
    logic [2:0]  sel_q, sel_d, s_q, s_d, rr_q, rr_d, last_q, last_d, ch, fall;
    logic [11:0] pre_q, pre_d;
    logic [15:0] cmp_q [8];
    logic [15:0] cmp_d [8];
`ifdef AVR_ALARM_PERIODIC_EN
    logic [15:0] per_q [8];
    logic [15:0] per_d [8];
`endif
    logic        wr, arm_wr, sel_ok, valid, tick, hit;
    logic [3:0]  j;

    assign wr      = bus.io_we & ~bus.io_re;
    assign arm_wr  = wr && bus.io_a == 3'd5;
    assign sel_ok  = {1'b0, sel_q} < 4'(NCH);
    assign valid   = |pend_q;
    assign bus.irq = ctrl_q[7] & valid;
    assign bus.io_do = bus.io_re ? rdata : 8'h00;

    // Search upward from rr, wrapping; with nothing pending ch shows the last granted channel.
    always_comb begin
        ch = last_q;
        j = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            j = {1'b0, rr_q} + 4'(i);
            j = (j >= 4'(NCH)) ? j - 4'(NCH) : j;
            if (pend_q[j[2:0]]) ch = j[2:0];
        end
    end

    always_comb begin
        case (bus.io_a)
            3'd0:    rdata = cnt_q[7:0];
            3'd1:    rdata = tmp_q;
            3'd2:    rdata = {5'b0, sel_q};
            3'd3:    rdata = sel_ok ? cmp_q[sel_q][7:0] : 8'h00;
            3'd4:    rdata = ctrl_q;
            3'd5:    rdata = arm_q;
            3'd6:    rdata = pend_q;
            default: rdata = {valid, 4'b0, ch};
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        tmp_d = tmp_q;
        sel_d = sel_q;
        ctrl_d = ctrl_q;
        arm_d = arm_q;
        pend_d = pend_q;
        rr_d = rr_q;
        last_d = last_q;
        pre_d = pre_q;
        cmp_d = cmp_q;
`ifdef AVR_ALARM_PERIODIC_EN
        per_d = per_q;
`endif
        s_d = (s_q == LAST) ? 3'd0 : s_q + 3'd1;
        fall = 3'b0;
        tick = 1'b0;
        if (ctrl_q[6] && s_q == LAST) begin
            pre_d = pre_q + 12'd1;
            fall = {pre_q[11], pre_q[7], pre_q[3]} & ~{pre_d[11], pre_d[7], pre_d[3]};
            tick = ctrl_q[1:0] == 2'd0 ? 1'b1 : ctrl_q[1:0] == 2'd1 ? fall[0] : ctrl_q[1:0] == 2'd2 ? fall[1] : fall[2];
            cnt_d = cnt_q + 16'(tick);
        end
        hit = arm_q[s_q] && cmp_q[s_q] == cnt_q &&
              !(wr && (bus.io_a == 3'd0 || (bus.io_a == 3'd3 && sel_q == s_q)));
        if (bus.io_re) begin
            if (bus.io_a == 3'd0) tmp_d = cnt_q[15:8];
            if (bus.io_a == 3'd3) tmp_d = sel_ok ? cmp_q[sel_q][15:8] : 8'h00;
            if (bus.io_a == 3'd7 && valid) begin
                pend_d[ch] = 1'b0;
                rr_d = (ch == LAST) ? 3'd0 : ch + 3'd1;
                last_d = ch;
            end
        end
        if (wr) begin
            case (bus.io_a)
                3'd0: begin
                    cnt_d = {tmp_q, bus.io_di};
                    s_d = 3'd0;
                    pre_d = '0;
                end
                3'd1: tmp_d = bus.io_di;
`ifdef AVR_ALARM_PERIODIC_EN
                3'd2: begin
                    if (bus.io_di[7:4] != 4'hF) sel_d = bus.io_di[2:0];
                    else if ({1'b0, bus.io_di[2:0]} < 4'(NCH)) per_d[bus.io_di[2:0]] = {tmp_q, 8'h00};
                end
`else
                3'd2: sel_d = bus.io_di[2:0];
`endif
                3'd3: begin
                    if (sel_ok) begin
                        cmp_d[sel_q] = {tmp_q, bus.io_di};
                        arm_d[sel_q] = 1'b1;
                        pend_d[sel_q] = 1'b0;
                    end
                end
                3'd4: ctrl_d = bus.io_di & 8'hC3;
                3'd5: arm_d = bus.io_di & CH_MASK;
                3'd6: pend_d = pend_q & ~bus.io_di;
                default: ;
            endcase
        end
        if (hit) begin
            pend_d[s_q] = 1'b1;
`ifdef AVR_ALARM_PERIODIC_EN
            if (per_q[s_q] != 16'h0) cmp_d[s_q] = cmp_q[s_q] + per_q[s_q];
            else if (!arm_wr) arm_d[s_q] = 1'b0;
`else
            if (!arm_wr) arm_d[s_q] = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            tmp_q <= '0;
            sel_q <= '0;
            ctrl_q <= '0;
            arm_q <= '0;
            pend_q <= '0;
            s_q <= '0;
            rr_q <= '0;
            last_q <= '0;
            pre_q <= '0;
            cmp_q <= '{default: '0};
`ifdef AVR_ALARM_PERIODIC_EN
            per_q <= '{default: '0};
`endif
        end else begin
            cnt_q <= cnt_d;
            tmp_q <= tmp_d;
            sel_q <= sel_d;
            ctrl_q <= ctrl_d;
            arm_q <= arm_d;
            pend_q <= pend_d;
            s_q <= s_d;
            rr_q <= rr_d;
            last_q <= last_d;
            pre_q <= pre_d;
            cmp_q <= cmp_d;
`ifdef AVR_ALARM_PERIODIC_EN
            per_q <= per_d;
`endif
        end
    end
endmodule

// File: tb/tb_avr_io_alarm.sv
// tb_avr_io_alarm: directed and randomized checks of the alarm scheduler against expectations derived from its register-level behaviour.
module tb_avr_io_alarm;
    localparam int NCH = 4;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    avr_io_alarm_if bus ();
    avr_io_alarm #(.NCH(NCH)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        bus.io_re = 1'b0;
        bus.io_we = 1'b1;
        bus.io_a = a;
        bus.io_di = d;
        @(posedge clk); #1;
        bus.io_we = 1'b0;
    endtask

    task automatic rd(input logic [2:0] a, output logic [7:0] d);
        bus.io_we = 1'b0;
        bus.io_re = 1'b1;
        bus.io_a = a;
        @(negedge clk);
        d = bus.io_do;
        @(posedge clk); #1;
        bus.io_re = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic setcnt(input logic [15:0] v);
        wr(3'd1, v[15:8]);
        wr(3'd0, v[7:0]);
    endtask

    task automatic setcmp(input logic [2:0] c, input logic [15:0] v);
        wr(3'd2, {5'b0, c});
        wr(3'd1, v[15:8]);
        wr(3'd3, v[7:0]);
    endtask

    task automatic rdcnt(output logic [15:0] v);
        logic [7:0] lo, hi;
        rd(3'd0, lo);
        rd(3'd1, hi);
        v = {hi, lo};
    endtask

    task automatic rdcmp(input logic [2:0] c, output logic [15:0] v);
        logic [7:0] lo, hi;
        wr(3'd2, {5'b0, c});
        rd(3'd3, lo);
        rd(3'd1, hi);
        v = {hi, lo};
    endtask

    // Counter advance after t clocks of running from a CNTL write: one tick per scan round, divided by 16 for PS=1.
    function automatic int advance(input int t, input int ps);
        return ps == 0 ? t / NCH : (t / NCH) / 16;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] d;
        logic [15:0] v, x;
        logic [7:0] exp_pend;
        int off [NCH];
        int ps, n, f;
        bus.io_re = 1'b0;
        bus.io_we = 1'b0;
        bus.io_a = '0;
        bus.io_di = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        for (int a = 0; a < 8; a++) begin
            rd(3'(a), d);
            chk($sformatf("reset_rd%0d", a), d, 16'h0);
        end
        chk("reset_irq", bus.irq, 16'h0);

        wr(3'd4, 8'h40);
        setcnt(16'h0000);
        setcmp(3'd2, 16'h0010);
        idle(16'h14 * NCH);
        wr(3'd4, 8'h00);
        rd(3'd6, d);
        chk("single_pend", d, 16'h04);
        rd(3'd5, d);
        chk("single_disarm", d, 16'h00);
        chk("irq_ie_off", bus.irq, 16'h0);
        wr(3'd4, 8'h80);
        chk("irq_ie_on", bus.irq, 16'h1);
        chk("do_gated", bus.io_do, 16'h0);
        wr(3'd6, 8'h04);
        chk("irq_w1c", bus.irq, 16'h0);

        setcmp(3'd0, 16'h0005);
        setcmp(3'd3, 16'h0005);
        setcnt(16'h0005);
        idle(2 * NCH);
        chk("vec_irq", bus.irq, 16'h1);
        rd(3'd7, d);
        chk("vec_first", d, 16'h80);
        rd(3'd7, d);
        chk("vec_second", d, 16'h83);
        rd(3'd7, d);
        chk("vec_empty", d, 16'h03);
        rd(3'd6, d);
        chk("vec_pend", d, 16'h00);
        chk("vec_irq_drop", bus.irq, 16'h0);

        setcnt(16'h1234);
        rd(3'd0, d);
        chk("cntl_low", d, 16'h34);
        rd(3'd1, d);
        chk("cntl_tmp", d, 16'h12);
        wr(3'd4, 8'h41);
        setcnt(16'h2000);
        idle(16 * NCH * 2 + 3 * NCH - 1);
        wr(3'd4, 8'h00);
        rdcnt(v);
        chk("ps1_cnt", v, 16'h2000 + 16'(advance(16 * NCH * 2 + 3 * NCH, 1)));

        for (int it = 0; it < 6; it++) begin
            ps = int'($urandom_range(0, 1));
            x = 16'($urandom);
            exp_pend = 8'h00;
            wr(3'd4, 8'h00);
            setcnt(x ^ 16'h8000);
            for (int c = 0; c < NCH; c++) begin
                off[c] = int'($urandom_range(0, ps == 0 ? 60 : 4));
                setcmp(3'(c), x + 16'(off[c]));
            end
            wr(3'd4, 8'(8'h40 | ps));
            setcnt(x);
            n = int'($urandom_range(20, 250));
            idle(n);
            wr(3'd4, 8'h00);
            idle(2 * NCH);
            f = advance(n + 1, ps);
            for (int c = 0; c < NCH; c++) if (off[c] <= f) exp_pend[c] = 1'b1;
            rdcnt(v);
            chk($sformatf("rand%0d_cnt", it), v, x + 16'(f));
            rd(3'd6, d);
            chk($sformatf("rand%0d_pend", it), d, 16'(exp_pend));
            rd(3'd5, d);
            chk($sformatf("rand%0d_arm", it), d, 16'(~exp_pend & 8'h0F));
        end

        wr(3'd5, 8'h00);
        wr(3'd6, 8'hFF);
        wr(3'd2, 8'h01);
        wr(3'd1, 8'h77);
        wr(3'd0, 8'h66);
        wr(3'd3, 8'h66);
        wr(3'd6, 8'h02);
        rd(3'd6, d);
        chk("set_beats_w1c", d, 16'h02);
        wr(3'd6, 8'h02);
        rd(3'd6, d);
        chk("w1c_clear", d, 16'h00);
        wr(3'd0, 8'h66);
        wr(3'd3, 8'h66);
        wr(3'd5, 8'h02);
        rd(3'd5, d);
        chk("arm_write_wins", d, 16'h02);
        rd(3'd6, d);
        chk("arm_race_pend", d, 16'h02);
        wr(3'd5, 8'h00);
        wr(3'd6, 8'hFF);

        wr(3'd1, 8'h5A);
        bus.io_re = 1'b1;
        bus.io_we = 1'b1;
        bus.io_a = 3'd1;
        bus.io_di = 8'hA5;
        @(negedge clk);
        chk("rw_read", bus.io_do, 16'h5A);
        @(posedge clk); #1;
        bus.io_re = 1'b0;
        bus.io_we = 1'b0;
        rd(3'd1, d);
        chk("rw_write_dropped", d, 16'h5A);

        wr(3'd2, 8'h05);
        rd(3'd2, d);
        chk("sel_stored", d, 16'h05);
        rd(3'd3, d);
        chk("sel_oob_read", d, 16'h00);
        wr(3'd1, 8'h11);
        wr(3'd3, 8'h22);
        rd(3'd5, d);
        chk("sel_oob_write", d, 16'h00);

`ifdef AVR_ALARM_PERIODIC_EN
        wr(3'd1, 8'h01);
        wr(3'd2, 8'hF1);
        setcmp(3'd1, 16'h0050);
        wr(3'd4, 8'h40);
        setcnt(16'h0000);
        idle(16'h60 * NCH);
        wr(3'd4, 8'h00);
        rdcmp(3'd1, v);
        chk("per_first_cmp", v, 16'h0150);
        rd(3'd6, d);
        chk("per_first_pend", d, 16'h02);
        wr(3'd6, 8'h02);
        wr(3'd4, 8'h40);
        idle(16'h100 * NCH);
        wr(3'd4, 8'h00);
        rdcmp(3'd1, v);
        chk("per_second_cmp", v, 16'h0250);
        rd(3'd5, d);
        chk("per_arm_kept", d, 16'h02);
        rd(3'd6, d);
        chk("per_second_pend", d, 16'h02);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
